// File: rtl/game_sound_pkg.sv
// Shared types and melody tables for the game sound player.
// Half-periods are in clock cycles before the per-build multiplier.
package game_sound_pkg;

  typedef enum logic {MEL_LOSE, MEL_WIN} melody_e;
  typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_e;

  localparam logic [9:0] WIN_FREQ  = 10'd1;
  localparam logic [9:0] LOSE_FREQ = 10'd0;
  localparam int LOSE_NOTES = 3;
  localparam int WIN_NOTES  = 4;
  localparam int MAX_HP     = 12;

  function automatic logic [3:0] half_period_base(melody_e m, logic [1:0] idx);
    logic [3:0] hp;
    hp = 4'd8;
    if (m == MEL_WIN) begin
      case (idx)
        2'd0:    hp = 4'd6;
        2'd1:    hp = 4'd5;
        2'd2:    hp = 4'd4;
        default: hp = 4'd3;
      endcase
    end else begin
      case (idx)
        2'd0:    hp = 4'd8;
        2'd1:    hp = 4'd10;
        default: hp = 4'd12;
      endcase
    end
    return hp;
  endfunction

  function automatic logic [1:0] last_note(melody_e m);
    return (m == MEL_WIN) ? 2'(WIN_NOTES - 1) : 2'(LOSE_NOTES - 1);
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles its output every half_period enabled cycles.
// clr restarts the wave low with the counter at zero.
import game_sound_pkg::*;

module tone_divider #(
  parameter int HP_W = 4
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            en,
  input  logic            clr,
  input  logic [HP_W-1:0] half_period,
  output logic            wave_o
);

  logic [HP_W-1:0] tone_cnt_q, tone_cnt_d;
  logic            wave_q, wave_d;

  always_comb begin
    tone_cnt_d = tone_cnt_q;
    wave_d     = wave_q;
    if (clr) begin
      tone_cnt_d = '0;
      wave_d     = 1'b0;
    end else if (en) begin
      if (tone_cnt_q == half_period - HP_W'(1)) begin
        tone_cnt_d = '0;
        wave_d     = ~wave_q;
      end else begin
        tone_cnt_d = tone_cnt_q + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tone_cnt_q <= '0;
      wave_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      wave_q     <= wave_d;
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/game_sound_player.sv
// Plays a short win/lose square-wave jingle on a rising edge of enable_sound.
// Reports busy while notes/gaps are in progress and a one-cycle done pulse.
import game_sound_pkg::*;

module game_sound_player #(
  parameter int NOTE_TICKS = 40,
  parameter int GAP_TICKS  = 4,
  parameter int HP_MULT    = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable_sound,
  input  logic [9:0] sound_freq,
  output logic       audio_out,
  output logic       busy,
  output logic [1:0] note_idx,
  output logic       done
);

  localparam int HP_W = $clog2(MAX_HP * HP_MULT + 1);
  localparam int NCW  = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam int GCW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_e          state_q, state_d;
  melody_e         melody_q, melody_d;
  logic [1:0]      note_idx_q, note_idx_d;
  logic [NCW-1:0]  note_cnt_q, note_cnt_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic            en_q;
  logic            trig, wave;
  logic [HP_W-1:0] half_period;

  assign trig        = enable_sound & ~en_q;
  assign half_period = HP_W'(HP_MULT * int'(half_period_base(melody_q, note_idx_q)));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      melody_q   <= MEL_LOSE;
      note_idx_q <= '0;
      note_cnt_q <= '0;
      gap_cnt_q  <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      melody_q   <= melody_d;
      note_idx_q <= note_idx_d;
      note_cnt_q <= note_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      en_q       <= enable_sound;
    end
  end

  always_comb begin
    state_d    = state_q;
    melody_d   = melody_q;
    note_idx_d = note_idx_q;
    note_cnt_d = note_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: if (trig) begin
        state_d    = PLAY;
        melody_d   = (sound_freq == WIN_FREQ) ? MEL_WIN : MEL_LOSE;
        note_idx_d = '0;
        note_cnt_d = '0;
      end
      PLAY: if (note_cnt_q == NCW'(NOTE_TICKS - 1)) begin
        note_cnt_d = '0;
        gap_cnt_d  = '0;
        if (note_idx_q == last_note(melody_q)) begin
          state_d    = DONE;
          note_idx_d = '0;
        end else begin
          state_d = GAP;
        end
      end else begin
        note_cnt_d = note_cnt_q + NCW'(1);
      end
      GAP: if (gap_cnt_q == GCW'(GAP_TICKS - 1)) begin
        gap_cnt_d  = '0;
        state_d    = PLAY;
        note_idx_d = note_idx_q + 2'd1;
      end else begin
        gap_cnt_d = gap_cnt_q + GCW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider held clear outside PLAY so every note starts low at count zero.
  tone_divider #(.HP_W(HP_W)) u_tone (
    .clk         (clk),
    .resetN      (resetN),
    .en          (state_q == PLAY),
    .clr         (state_q != PLAY),
    .half_period (half_period),
    .wave_o      (wave)
  );

  always_comb begin
    busy      = (state_q == PLAY) || (state_q == GAP);
    done      = (state_q == DONE);
    audio_out = wave & (state_q == PLAY);
    note_idx  = note_idx_q;
  end

endmodule

// File: tb/tb_game_sound_player.sv
// Directed + randomized bench for game_sound_player; two instances (HP_MULT 1 and 2)
// are checked every cycle against a timeline model of the jingle.
module tb_game_sound_player;

  localparam int NT = 40;
  localparam int GT = 4;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic [1:0]      en = '0;
  logic [1:0][9:0] fr = '0;
  logic [1:0]      aud, bsy, dn;
  logic [1:0][1:0] idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_sound_player #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .HP_MULT(1)) dut0 (
    .clk(clk), .resetN(resetN), .enable_sound(en[0]), .sound_freq(fr[0]),
    .audio_out(aud[0]), .busy(bsy[0]), .note_idx(idx[0]), .done(dn[0]));

  game_sound_player #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .HP_MULT(2)) dut1 (
    .clk(clk), .resetN(resetN), .enable_sound(en[1]), .sound_freq(fr[1]),
    .audio_out(aud[1]), .busy(bsy[1]), .note_idx(idx[1]), .done(dn[1]));

  function automatic int hpm(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int base_hp(input bit win, input int n);
    int lose_t[3] = '{8, 10, 12};
    int win_t[4]  = '{6, 5, 4, 3};
    return win ? win_t[n] : lose_t[n];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int d, input string tag, input logic ea, input logic eb,
                         input logic ed, input logic [1:0] ei);
    chk({tag, "/audio"}, 32'(aud[d]), 32'(ea));
    chk({tag, "/busy"},  32'(bsy[d]), 32'(eb));
    chk({tag, "/done"},  32'(dn[d]),  32'(ed));
    chk({tag, "/idx"},   32'(idx[d]), 32'(ei));
  endtask

  // Melody timeline: note n occupies offsets n*(NT+GT) .. +NT-1, then a silent gap;
  // done appears at offset dur. Offset 0 is the first cycle busy is high.
  task automatic run_mel(input int d, input logic [9:0] freq, input int hold,
                         input int pulse_at, input int stop_at, input string tag);
    bit win;
    int notes, dur, last, o, n, k, hp;
    logic ea, eb, ed;
    logic [1:0] ei;
    win   = (freq == 10'd1);
    notes = win ? 4 : 3;
    dur   = notes * NT + (notes - 1) * GT;
    last  = (hold + 2 > dur + 3) ? hold + 2 : dur + 3;
    if (stop_at > 0) last = stop_at;
    fr[d] = freq;
    en[d] = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      o = c - 1; ea = 1'b0; eb = 1'b0; ed = 1'b0; ei = 2'd0;
      if (o < dur) begin
        n  = o / (NT + GT);
        k  = o % (NT + GT);
        eb = 1'b1;
        ei = 2'(n);
        if (k < NT) begin
          hp = base_hp(win, n) * hpm(d);
          ea = ((k / hp) % 2) == 1;
        end
      end else if (o == dur) begin
        ed = 1'b1;
      end
      chk_all(d, tag, ea, eb, ed, ei);
      fr[d] = 10'($urandom);
      if (c == hold) en[d] = 1'b0;
      if (pulse_at > 0 && c == pulse_at) en[d] = 1'b1;
      if (pulse_at > 0 && c == pulse_at + 1) en[d] = 1'b0;
    end
    en[d] = 1'b0;
  endtask

  initial begin
    int d, sel, hold, pls;
    logic [9:0] f;
    en[1] = 1'b1;
    fr[1] = 10'd1;
    #3;
    chk_all(0, "reset0", 1'b0, 1'b0, 1'b0, 2'd0);
    chk_all(1, "reset1", 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    resetN = 1'b1;
    // enable already high coming out of reset must start a melody
    run_mel(1, 10'd1, 5, 0, 0, "win_hp2");

    run_mel(0, 10'd1, 5, 0, 0, "win");
    run_mel(0, 10'd0, 5, 0, 0, "lose");
    run_mel(0, 10'd1, 300, 0, 0, "hold");
    run_mel(0, 10'd1, 2, 60, 0, "repulse");
    run_mel(0, 10'd7, 4, 0, 0, "oor");

    for (int r = 0; r < 8; r++) begin
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 2));
      f   = (sel == 0) ? 10'd1 : (sel == 1) ? 10'd0 : 10'($urandom_range(2, 1023));
      hold = int'($urandom_range(1, 8));
      pls  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(hold + 2, 120)) : 0;
      run_mel(d, f, hold, pls, 0, "rand");
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    // Abort during note 1 of a win melody.
    run_mel(0, 10'd1, 3, 0, 51, "pre_rst");
    resetN = 1'b0;
    #1;
    chk_all(0, "in_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      chk_all(0, "post_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
